flag_reader: RTL and testbench

FLAG_READER -- requirements
Module: flag_reader

---
 rtl/flag_pkg.sv | 25 ++
 rtl/flag_reader_if.sv | 32 +++
 rtl/sync2.sv | 28 ++
 rtl/flag_reader.sv | 105 ++++++++++
 tb/tb_flag_reader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the flag reader and the writer-side model.
// Holds the FSM state encoding, the datapath widths, the default timing
// constants, and a saturating increment for the r-asserted counter.
package flag_pkg;

  localparam int DATA_W         = 8;
  localparam int CNT_W          = 8;
  localparam int DEF_CLR_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_WAITLOW = 3'd3,
    ST_HOLD    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/flag_reader_if.sv
// Bundle between the flag reader, the external SR flag latch / writer and
// the downstream consumer.
//   flag_q    : q of the external flag latch (asynchronous to the clock)
//   data_in   : writer byte, stable while flag_q=1
//   r         : reset command to the flag latch, active high
//   data_out  : captured byte
//   valid_out : data_out holds an unconsumed byte
//   ready_in  : downstream accepts data_out on valid_out & ready_in
//   error     : sticky, flag did not drop in time
// master = the reader, slave = the environment around it.
interface flag_reader_if;
  import flag_pkg::*;

  logic              flag_q;
  logic [DATA_W-1:0] data_in;
  logic              r;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;
  logic              error;

  modport master (
    input  flag_q, data_in, ready_in,
    output r, data_out, valid_out, error
  );

  modport slave (
    output flag_q, data_in, ready_in,
    input  r, data_out, valid_out, error
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clock  : destination clock
//   reset_ : asynchronous active-low reset, clears both flops
//   d      : asynchronous input
//   q      : synchronized output, two clock edges after d
module sync2 (
  input  logic clock,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/flag_reader.sv
// Reads bytes handed over through an external SR flag latch.
// The writer sets the latch when data_in is valid; this block synchronizes
// the flag, captures the byte, pulses r to clear the latch, waits for the
// flag to fall, then presents the byte with a valid/ready handshake.
// A flag that never falls within TIMEOUT r-cycles parks the block in a
// sticky error state until reset.
//   clock  : single clock, rising edge
//   reset_ : asynchronous active-low reset
//   bus    : flag_reader_if.master (flag_q, data_in, r, data_out,
//            valid_out, ready_in, error)
// Parameters: CLR_CYCLES (1..7) r cycles per clear request,
//             TIMEOUT (CLR_CYCLES..255) max total r-asserted cycles.
module flag_reader
  import flag_pkg::*;
#(
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic           clock,
  input logic           reset_,
  flag_reader_if.master bus
);

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  logic              flag_s;
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              capture;
  logic              r_reg;
  logic              valid_reg;
  logic              error_reg;
  logic [DATA_W-1:0] data_reg;

  sync2 u_sync (
    .clock  (clock),
    .reset_ (reset_),
    .d      (bus.flag_q),
    .q      (flag_s)
  );

  // cnt counts every r-asserted cycle since entering CLEAR, so in WAITLOW
  // it already includes the CLEAR cycles and is compared against TIMEOUT.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (flag_s) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        cnt_next   = '0;
        state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_next = sat_inc(cnt_reg);
        if (cnt_reg >= CLR_LAST) state_next = ST_WAITLOW;
      end
      ST_WAITLOW: begin
        cnt_next = sat_inc(cnt_reg);
        if (!flag_s)                state_next = ST_HOLD;
        else if (cnt_reg >= TO_LAST) state_next = ST_FAULT;
      end
      ST_HOLD: begin
        // A flag set again here is left alone until IDLE samples it.
        if (bus.ready_in) state_next = ST_IDLE;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so r and
  // valid_out change cleanly on the clock edge with no decode glitches.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      r_reg     <= 1'b0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      r_reg     <= (state_next == ST_CLEAR) || (state_next == ST_WAITLOW);
      valid_reg <= (state_next == ST_HOLD);
      error_reg <= (state_next == ST_FAULT);
      if (capture) data_reg <= bus.data_in;
    end
  end

  assign bus.r         = r_reg;
  assign bus.valid_out = valid_reg;
  assign bus.error     = error_reg;
  assign bus.data_out  = data_reg;

endmodule

// File: tb/tb_flag_reader.sv
module tb_flag_reader;
  import flag_pkg::*;

  logic       clock = 1'b0;
  logic       reset_;
  logic       set_req;
  logic       w_clr;
  logic       latch_init;
  logic       flag_q;
  logic [7:0] data_in;
  logic       ready_in;

  int n_vec  = 0;
  int n_miss = 0;

  flag_reader_if bus_if ();

  assign bus_if.flag_q   = flag_q;
  assign bus_if.data_in  = data_in;
  assign bus_if.ready_in = ready_in;

  flag_reader #(.CLR_CYCLES(2), .TIMEOUT(15)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus_if.master)
  );

  always #5 clock = ~clock;

  // Writer-side SR flag latch: set dominates, r or writer withdraw clear it.
  always_latch begin
    if (latch_init)            flag_q <= 1'b0;
    else if (set_req)          flag_q <= 1'b1;
    else if (bus_if.r || w_clr) flag_q <= 1'b0;
  end

  // Monitor on the falling edge: r-cycle count, deliveries, valid rises.
  int         cyc = 0;
  int         r_total = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] deliv[$];
  int         rise_q[$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus_if.r === 1'b1) r_total = r_total + 1;
    if (bus_if.valid_out === 1'b1 && ready_in === 1'b1) deliv.push_back(bus_if.data_out);
    if (bus_if.valid_out === 1'b1 && valid_prev !== 1'b1) rise_q.push_back(cyc);
    valid_prev = bus_if.valid_out;
  end

  typedef struct {
    logic [7:0] data;
    int         stall;
    logic [7:0] exp_data;
    int         exp_r;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus_if.valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic       seen;
    int         base_r, base_d, base_rise, bad, rd, dd;

    vecs[0] = '{data: 8'hA5, stall: 0, exp_data: 8'hA5, exp_r: 3};
    vecs[1] = '{data: 8'h3C, stall: 4, exp_data: 8'h3C, exp_r: 3};
    vecs[2] = '{data: 8'h00, stall: 0, exp_data: 8'h00, exp_r: 3};
    vecs[3] = '{data: 8'hFF, stall: 1, exp_data: 8'hFF, exp_r: 3};
    vecs[4] = '{data: 8'h5A, stall: 0, exp_data: 8'h5A, exp_r: 3};

    reset_     = 1'b1;
    set_req    = 1'b0;
    w_clr      = 1'b0;
    latch_init = 1'b1;
    data_in    = 8'h00;
    ready_in   = 1'b0;
    #2;
    reset_     = 1'b0;
    latch_init = 1'b0;
    #1;
    check("reset_r", bus_if.r, 0);
    check("reset_valid", bus_if.valid_out, 0);
    check("reset_error", bus_if.error, 0);
    check("reset_data", bus_if.data_out, 8'h00);
    repeat (3) tick();
    reset_ = 1'b1;
    repeat (3) tick();
    check("idle_r", bus_if.r, 0);

    // Table-driven single bytes with optional backpressure.
    foreach (vecs[k]) begin
      tick();
      base_r   = r_total;
      base_d   = deliv.size();
      ready_in = (vecs[k].stall == 0);
      data_in  = vecs[k].data;
      set_req  = 1'b1;
      tick();
      set_req  = 1'b0;
      wait_valid(seen);
      check("valid_seen", seen, 1);
      check("data_out", bus_if.data_out, vecs[k].exp_data);
      bad = 0;
      repeat (vecs[k].stall) begin
        @(negedge clock);
        if (bus_if.valid_out !== 1'b1 || bus_if.data_out !== vecs[k].exp_data) bad++;
      end
      check("hold_stable", bad, 0);
      if (vecs[k].stall > 0) begin
        tick();
        ready_in = 1'b1;
      end
      tick();
      check("valid_drop", bus_if.valid_out, 0);
      check("r_cycles", r_total - base_r, vecs[k].exp_r);
      check("deliv_count", deliv.size() - base_d, 1);
      if (deliv.size() > 0) check("deliv_data", deliv[deliv.size()-1], vecs[k].exp_data);
      $display("vector %0d: data %02h stall %0d delivered", k, vecs[k].data, vecs[k].stall);
    end

    // Backpressure for 10 cycles with a second flag set during HOLD.
    tick();
    ready_in = 1'b0;
    base_d   = deliv.size();
    data_in  = 8'h3C;
    set_req  = 1'b1;
    tick();
    set_req  = 1'b0;
    wait_valid(seen);
    check("bp_valid_seen", seen, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus_if.valid_out !== 1'b1 || bus_if.data_out !== 8'h3C) bad++;
      if (i == 2) begin
        data_in = 8'h77;
        set_req = 1'b1;
      end
      if (i == 3) set_req = 1'b0;
    end
    check("bp_hold_10", bad, 0);
    tick();
    ready_in = 1'b1;
    tick();
    check("bp_valid_drop", bus_if.valid_out, 0);
    wait_valid(seen);
    check("bp_second_seen", seen, 1);
    check("bp_second_data", bus_if.data_out, 8'h77);
    tick();
    check("bp_deliv_count", deliv.size() - base_d, 2);
    if (deliv.size() >= 2) begin
      check("bp_order_0", deliv[deliv.size()-2], 8'h3C);
      check("bp_order_1", deliv[deliv.size()-1], 8'h77);
    end
    $display("backpressure: 3c then 77");

    // Burst of four bytes with ready_in held high.
    tick();
    ready_in  = 1'b1;
    base_d    = deliv.size();
    base_rise = rise_q.size();
    for (int k = 1; k <= 4; k++) begin
      data_in = 8'(k);
      set_req = 1'b1;
      tick();
      set_req = 1'b0;
      wait_valid(seen);
      check("burst_seen", seen, 1);
      tick();
    end
    check("burst_count", deliv.size() - base_d, 4);
    for (int k = 0; k < 4; k++)
      if (base_d + k < deliv.size()) check("burst_order", deliv[base_d+k], 8'(k + 1));
    for (int k = 1; k < 4; k++)
      if (base_rise + k < rise_q.size())
        check("burst_spacing", rise_q[base_rise+k] - rise_q[base_rise+k-1], 8);
    $display("burst: 01..04 delivered");

    // Stuck flag: writer holds the flag set.
    tick();
    base_r  = r_total;
    base_d  = deliv.size();
    data_in = 8'hEE;
    set_req = 1'b1;
    repeat (40) tick();
    check("stuck_r_cycles", r_total - base_r, 15);
    check("stuck_error", bus_if.error, 1);
    check("stuck_r_low", bus_if.r, 0);
    check("stuck_valid_low", bus_if.valid_out, 0);
    set_req = 1'b0;
    repeat (5) tick();
    check("stuck_error_sticky", bus_if.error, 1);
    check("stuck_no_more_r", r_total - base_r, 15);
    check("stuck_no_deliv", deliv.size() - base_d, 0);
    reset_ = 1'b0;
    #1;
    check("fault_rst_error", bus_if.error, 0);
    check("fault_rst_data", bus_if.data_out, 8'h00);
    tick();
    reset_ = 1'b1;
    wait_valid(seen);
    check("relatch_seen", seen, 1);
    check("relatch_data", bus_if.data_out, 8'hEE);
    tick();
    check("relatch_error", bus_if.error, 0);
    $display("stuck flag: fault after 15 r cycles, recovered by reset");

    // Reset during the second r cycle of a clear.
    tick();
    data_in = 8'h96;
    set_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus_if.r === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_r_seen", seen, 1);
    tick();
    check("mid_r_second", bus_if.r, 1);
    reset_ = 1'b0;
    #1;
    check("mid_rst_r", bus_if.r, 0);
    check("mid_rst_valid", bus_if.valid_out, 0);
    check("mid_rst_error", bus_if.error, 0);
    check("mid_rst_data", bus_if.data_out, 8'h00);
    tick();
    set_req = 1'b0;
    tick();
    check("mid_flag_kept", flag_q, 1);
    base_r = r_total;
    reset_ = 1'b1;
    wait_valid(seen);
    check("mid_recap_seen", seen, 1);
    check("mid_recap_data", bus_if.data_out, 8'h96);
    tick();
    check("mid_recap_r", r_total - base_r, 3);
    $display("reset mid-clear: 96 recaptured");

    // Glitches: a pulse between edges, then a pulse spanning one edge.
    tick();
    base_r  = r_total;
    base_d  = deliv.size();
    set_req = 1'b1;
    #2;
    set_req = 1'b0;
    w_clr   = 1'b1;
    #1;
    w_clr   = 1'b0;
    repeat (20) tick();
    check("glitch_a_r", r_total - base_r, 0);
    check("glitch_a_deliv", deliv.size() - base_d, 0);
    check("glitch_a_error", bus_if.error, 0);
    base_r  = r_total;
    base_d  = deliv.size();
    data_in = 8'hC3;
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    w_clr   = 1'b1;
    #2;
    w_clr   = 1'b0;
    repeat (20) tick();
    rd = r_total - base_r;
    dd = deliv.size() - base_d;
    check("glitch_b_outcome", ((rd == 0 && dd == 0) || (rd == 3 && dd == 1)) ? 1 : 0, 1);
    check("glitch_b_error", bus_if.error, 0);
    check("glitch_b_r_low", bus_if.r, 0);
    $display("glitch: r cycles %0d, deliveries %0d", rd, dd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
